// File: rtl/mmio_timer.sv
// mmio_timer: bus-mapped prescaled 32-bit timer with compare/reload and irq.
// Optional overflow flag is enabled by defining MMIO_TIMER_OVF_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic        hit,
  output logic        irq
);

  logic [2:0]  ctrl, ctrl_n;
  logic [15:0] prescale, prescale_n;
  logic [15:0] pre_cnt, pre_n;
  logic [31:0] compare, compare_n;
  logic [31:0] count, count_n;
  logic        match, match_n;
  logic        ovf, ovf_n;
  logic        irq_n;
  logic [2:0]  off;
  logic        wr;
  logic        wr_ctrl, wr_pre, wr_cmp;
  logic        wr_cnt, wr_sta;
  logic        tick, eq, rld;
  logic        unused_ok;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  assign hit = (daddr[31:5] == BASE_ADDR[31:5]);
  assign off = daddr[4:2];
  assign unused_ok = ^daddr[1:0];
  assign wr = hit & (|we);

  assign wr_ctrl = wr & (off == 3'd0);
  assign wr_pre  = wr & (off == 3'd1);
  assign wr_cmp  = wr & (off == 3'd2);
  assign wr_cnt  = wr & (off == 3'd3);
  assign wr_sta  = wr & (off == 3'd4);

  always_comb begin
    ctrl_n = ctrl;
    if (wr_ctrl & we[0]) ctrl_n = dwdata[2:0];

    prescale_n = prescale;
    if (wr_pre & we[0]) prescale_n[7:0]  = dwdata[7:0];
    if (wr_pre & we[1]) prescale_n[15:8] = dwdata[15:8];

    compare_n = wr_cmp ? merge(compare, dwdata, we) : compare;

    // a write that drops en suppresses the tick on that edge
    tick = ctrl[0] & ctrl_n[0] & (pre_cnt == prescale);
    pre_n = 16'd0;
    if (ctrl[0] & ctrl_n[0] & ~tick) pre_n = pre_cnt + 16'd1;

    eq  = (count == compare);
    rld = eq & ctrl[1];

    count_n = count;
    if (wr_cnt)
      count_n = merge(count, dwdata, we);
    else if (tick)
      count_n = rld ? 32'd0 : count + 32'd1;

    match_n = (tick & eq) |
              (match & ~(wr_sta & we[0] & dwdata[0]));
`ifdef MMIO_TIMER_OVF_EN
    ovf_n = (tick & ~wr_cnt & ~rld & (&count)) |
            (ovf & ~(wr_sta & we[0] & dwdata[1]));
`else
    ovf_n = 1'b0;
`endif
    irq_n = ctrl[2] & (match_n | ovf_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= 3'd0;
      prescale <= 16'd0;
      pre_cnt  <= 16'd0;
      compare  <= 32'd0;
      count    <= 32'd0;
      match    <= 1'b0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_n;
      prescale <= prescale_n;
      pre_cnt  <= pre_n;
      compare  <= compare_n;
      count    <= count_n;
      match    <= match_n;
      ovf      <= ovf_n;
      irq      <= irq_n;
    end
  end

  always_comb begin
    drdata = 32'd0;
    if (hit) begin
      unique case (off)
        3'd0:    drdata = {29'd0, ctrl};
        3'd1:    drdata = {16'd0, prescale};
        3'd2:    drdata = compare;
        3'd3:    drdata = count;
        3'd4:    drdata = {30'd0, ovf, match};
        default: drdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed checks of decode, prescale, match, reload,
// collisions, byte enables, overflow and mid-run reset.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PRE  = 32'h04;
  localparam logic [31:0] A_CMP  = 32'h08;
  localparam logic [31:0] A_CNT  = 32'h0C;
  localparam logic [31:0] A_STA  = 32'h10;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic        hit;
  logic        irq;

  int total;
  int bad;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .reset(reset),
    .daddr(daddr),
    .dwdata(dwdata),
    .we(we),
    .drdata(drdata),
    .hit(hit),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] exp
  );
    daddr = BASE + a;
    we = 4'd0;
    #1;
    chk(tag, drdata, exp);
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    daddr = BASE + a;
    dwdata = d;
    we = be;
    @(posedge clk);
    #1;
    we = 4'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] seq [8];

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    we = 4'd0;
    daddr = 32'd0;
    dwdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    rd("rst_ctrl", A_CTRL, 32'd0);
    rd("rst_pre", A_PRE, 32'd0);
    rd("rst_cmp", A_CMP, 32'd0);
    rd("rst_cnt", A_CNT, 32'd0);
    rd("rst_sta", A_STA, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    daddr = BASE + 32'h1C;
    #1;
    chk("hit_1c", {31'd0, hit}, 32'd1);
    chk("rd_1c", drdata, 32'd0);
    daddr = BASE + 32'h20;
    #1;
    chk("hit_20", {31'd0, hit}, 32'd0);

    // prescaled match, no reload
    wr(A_PRE, 32'd2, 4'hF);
    wr(A_CMP, 32'd3, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    step(11);
    rd("pm_cnt11", A_CNT, 32'd3);
    rd("pm_sta11", A_STA, 32'd0);
    step(1);
    rd("pm_sta12", A_STA, 32'd1);
    rd("pm_cnt12", A_CNT, 32'd4);
    step(1);
    chk("pm_irq13", {31'd0, irq}, 32'd1);
    step(2);
    rd("pm_cnt15", A_CNT, 32'd5);
    daddr = BASE + 32'h2C;
    #1;
    chk("offwin_rd", drdata, 32'd0);
    wr(A_STA, 32'd1, 4'hF);
    rd("pm_w1c_sta", A_STA, 32'd0);
    chk("pm_w1c_irq", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'd0, 4'hF);

    // auto-reload, prescale 0
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    seq[0] = 32'd0; seq[1] = 32'd1;
    seq[2] = 32'd2; seq[3] = 32'd3;
    seq[4] = 32'd4; seq[5] = 32'd5;
    seq[6] = 32'd0; seq[7] = 32'd1;
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("rl_cnt%0d", i), A_CNT, seq[i]);
      step(1);
    end
    rd("rl_sta", A_STA, 32'd1);
    chk("rl_irq", {31'd0, irq}, 32'd0);

    // count write beats the tick on the same edge
    wr(A_CNT, 32'h100, 4'hF);
    rd("col_cnt", A_CNT, 32'h100);
    wr(A_CTRL, 32'd0, 4'hF);
    rd("dis_cnt", A_CNT, 32'h100);

    // hardware match set beats W1C clear
    wr(A_STA, 32'd1, 4'hF);
    rd("col_clr", A_STA, 32'd0);
    wr(A_CNT, 32'd4, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    step(1);
    rd("col_cnt5", A_CNT, 32'd5);
    wr(A_STA, 32'd1, 4'hF);
    rd("col_sta", A_STA, 32'd1);
    rd("col_rld", A_CNT, 32'd0);
    wr(A_CTRL, 32'd0, 4'hF);

    // byte enables
    wr(A_CMP, 32'hAABB_CCDD, 4'hF);
    wr(A_CMP, 32'h1122_3344, 4'b0101);
    rd("be_cmp", A_CMP, 32'hAA22_CC44);

    // overflow
    wr(A_STA, 32'd3, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CMP, 32'h10, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    step(1);
    rd("ov_cnt1", A_CNT, 32'hFFFF_FFFF);
    rd("ov_sta1", A_STA, 32'd0);
    chk("ov_irq1", {31'd0, irq}, 32'd0);
    step(1);
    rd("ov_cnt2", A_CNT, 32'd0);
`ifdef MMIO_TIMER_OVF_EN
    rd("ov_sta2", A_STA, 32'd2);
    step(1);
    chk("ov_irq3", {31'd0, irq}, 32'd1);
`else
    rd("ov_sta2", A_STA, 32'd0);
    step(1);
    chk("ov_irq3", {31'd0, irq}, 32'd0);
`endif

    // mid-run reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd("mr_ctrl", A_CTRL, 32'd0);
    rd("mr_cmp", A_CMP, 32'd0);
    rd("mr_sta", A_STA, 32'd0);
    chk("mr_irq", {31'd0, irq}, 32'd0);
    step(2);
    rd("mr_cnt", A_CNT, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
